// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: sweeps every register to INIT_VALUE after reset, then
// round-robin arbitrates NUM_REQ valid/ready requesters onto the single write port.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clock,
  input  logic                             resetN,
  input  logic [NUM_REQ-1:0]               reqValid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    reqAddress,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    reqData,
  output logic [NUM_REQ-1:0]               reqReady,
  output logic                             writeRegister,
  output logic [ADDR_WIDTH-1:0]            writeAddress,
  output logic [DATA_WIDTH-1:0]            writeData,
  output logic [1:0]                       grantIndex,
  output logic                             initDone
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] counter;
  logic [1:0] ptr;
  logic found;
  int win;
  // first valid requester at or above the pointer, wrapping modulo NUM_REQ
  always_comb begin
    found = 1'b0;
    win = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && reqValid[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win = (int'(ptr) + k) % NUM_REQ;
      end
    end
    state_next = (state == INIT && &counter) ? RUN : state;
  end
  assign reqReady = (state == RUN && found) ? NUM_REQ'(1) << win : '0;
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= INIT;
      counter <= '0;
      ptr <= '0;
      writeRegister <= 1'b0;
      writeAddress <= '0;
      writeData <= '0;
      grantIndex <= '0;
      initDone <= 1'b0;
    end else begin
      state <= state_next;
      if (state == INIT) begin
        writeRegister <= 1'b1;
        writeAddress <= counter;
        writeData <= INIT_VALUE;
        grantIndex <= '0;
        counter <= counter + 1'b1;
        if (&counter) initDone <= 1'b1;
      end else if (found) begin
        writeRegister <= 1'b1;
        writeAddress <= reqAddress[win*ADDR_WIDTH +: ADDR_WIDTH];
        writeData <= reqData[win*DATA_WIDTH +: DATA_WIDTH];
        grantIndex <= 2'(win);
        ptr <= 2'((win + 1) % NUM_REQ);
      end else begin
        writeRegister <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench; expected writes are queued as stimulus is
// driven and popped by a negedge monitor whenever the write port should show a write.
module tb_regfile_write_arbiter;
  logic clock = 1'b0;
  logic resetN;
  logic [2:0] reqValid;
  logic [14:0] reqAddress;
  logic [95:0] reqData;
  logic [2:0] reqReady;
  logic writeRegister;
  logic [4:0] writeAddress;
  logic [31:0] writeData;
  logic [1:0] grantIndex;
  logic initDone;

  typedef struct {logic [4:0] a; logic [31:0] d; logic [1:0] g;} exp_t;
  exp_t q[$];
  logic [4:0] addr_m[3];
  logic [31:0] data_m[3];
  int ptr_m;
  int checks = 0;
  int fails = 0;
  logic mon_en = 1'b0;

  regfile_write_arbiter dut (
    .clock(clock), .resetN(resetN), .reqValid(reqValid), .reqAddress(reqAddress),
    .reqData(reqData), .reqReady(reqReady), .writeRegister(writeRegister),
    .writeAddress(writeAddress), .writeData(writeData), .grantIndex(grantIndex),
    .initDone(initDone)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (writeRegister !== 1'b1 || writeAddress !== e.a || writeData !== e.d || grantIndex !== e.g) begin
          fails++;
          $display("FAIL write_port: got we=%b a=%0d d=%h g=%0d, expected we=1 a=%0d d=%h g=%0d",
                   writeRegister, writeAddress, writeData, grantIndex, e.a, e.d, e.g);
        end
      end else if (writeRegister !== 1'b0) begin
        fails++;
        $display("FAIL idle_port: got we=%b a=%0d d=%h, expected we=0", writeRegister, writeAddress, writeData);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic step(input logic [2:0] v, output logic [2:0] ready_exp);
    int w;
    reqValid = v;
    for (int i = 0; i < 3; i++) begin
      reqAddress[i*5 +: 5] = addr_m[i];
      reqData[i*32 +: 32] = data_m[i];
    end
    w = -1;
    for (int k = 0; k < 3; k++) if (w < 0 && v[(ptr_m + k) % 3]) w = (ptr_m + k) % 3;
    ready_exp = (w < 0) ? 3'b000 : 3'b001 << w;
    if (w >= 0) begin
      q.push_back('{addr_m[w], data_m[w], 2'(w)});
      ptr_m = (w + 1) % 3;
    end
    #1;
  endtask

  task automatic do_init(input logic [2:0] v);
    reqValid = v;
    for (int i = 0; i < 3; i++) begin
      reqAddress[i*5 +: 5] = addr_m[i];
      reqData[i*32 +: 32] = data_m[i];
    end
    ptr_m = 0;
    resetN = 1'b1;
    mon_en = 1'b1;
    #1;
    for (int k = 0; k < 32; k++) begin
      q.push_back('{5'(k), 32'h0, 2'd0});
      checks++;
      if (reqReady !== 3'b000) begin
        fails++;
        $display("FAIL init_ready: edge %0d got %b, expected 000", k + 1, reqReady);
      end
      tick();
      checks++;
      if (initDone !== (k == 31)) begin
        fails++;
        $display("FAIL init_done: edge %0d got %b, expected %b", k + 1, initDone, k == 31);
      end
    end
  endtask

  task automatic apply_reset_check(input string name);
    resetN = 1'b0;
    mon_en = 1'b0;
    q.delete();
    ptr_m = 0;
    #1;
    checks++;
    if ({writeRegister, writeAddress, writeData, grantIndex, initDone, reqReady} !== '0) begin
      fails++;
      $display("FAIL %s: got we=%b a=%0d d=%h g=%0d done=%b rdy=%b, expected all 0",
               name, writeRegister, writeAddress, writeData, grantIndex, initDone, reqReady);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    reqValid = 3'b000;
    reqAddress = '0;
    reqData = '0;
    tick();
    tick();
    reqValid = 3'b111;
    apply_reset_check("reset_values");
    tick();
  endtask

  task automatic test_init_sweep();
    logic [2:0] re;
    do_init(3'b000);
    step(3'b000, re);
    checks++;
    if (reqReady !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_init: got %b, expected 000", reqReady);
    end
    tick();
  endtask

  task automatic test_request_during_init();
    logic [2:0] re;
    int exp_g[6] = '{0, 1, 2, 0, 1, 2};
    apply_reset_check("reset_before_req_init");
    tick();
    for (int i = 0; i < 3; i++) begin
      addr_m[i] = 5'(i * 7 + 3);
      data_m[i] = 32'hC0DE_0000 + 32'(i * 17 + 1);
    end
    do_init(3'b111);
    for (int c = 0; c < 6; c++) begin
      step(3'b111, re);
      checks++;
      if (reqReady !== re) begin
        fails++;
        $display("FAIL rr_ready: cycle %0d got %b, expected %b", c, reqReady, re);
      end
      tick();
      checks++;
      if (grantIndex !== 2'(exp_g[c])) begin
        fails++;
        $display("FAIL rr_grant: cycle %0d got %0d, expected %0d", c, grantIndex, exp_g[c]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [2:0] re;
    int exp_g[4] = '{0, 2, 0, 2};
    for (int c = 0; c < 4; c++) begin
      step(3'b101, re);
      checks++;
      if (reqReady !== re) begin
        fails++;
        $display("FAIL fair_ready: cycle %0d got %b, expected %b", c, reqReady, re);
      end
      tick();
      checks++;
      if (grantIndex !== 2'(exp_g[c]) || initDone !== 1'b1) begin
        fails++;
        $display("FAIL fair_grant: cycle %0d got g=%0d done=%b, expected g=%0d done=1",
                 c, grantIndex, initDone, exp_g[c]);
      end
    end
  endtask

  task automatic test_collision();
    logic [2:0] re;
    addr_m[0] = 5'd5;
    data_m[0] = 32'hAAAA_AAAA;
    addr_m[1] = 5'd5;
    data_m[1] = 32'h5555_5555;
    step(3'b011, re);
    tick();
    step(3'b010, re);
    tick();
    checks++;
    if (writeAddress !== 5'd5 || writeData !== 32'h5555_5555) begin
      fails++;
      $display("FAIL collision_last: got a=%0d d=%h, expected a=5 d=55555555", writeAddress, writeData);
    end
  endtask

  task automatic test_withdrawal();
    logic [2:0] re;
    addr_m[0] = 5'd0;
    data_m[0] = 32'h0000_0F0F;
    addr_m[1] = 5'd17;
    data_m[1] = 32'hDEAD_BEEF;
    addr_m[2] = 5'd31;
    data_m[2] = 32'h1234_5678;
    step(3'b011, re);
    tick();
    step(3'b000, re);
    checks++;
    if (reqReady !== 3'b000) begin
      fails++;
      $display("FAIL withdraw_ready: got %b, expected 000", reqReady);
    end
    tick();
    step(3'b111, re);
    tick();
    checks++;
    if (grantIndex !== 2'd1) begin
      fails++;
      $display("FAIL withdraw_ptr: got %0d, expected 1", grantIndex);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] re;
    for (int c = 0; c < 4; c++) begin
      data_m[2] = 32'hB2B0_0000 + 32'(c);
      step(3'b100, re);
      checks++;
      if (reqReady !== 3'b100) begin
        fails++;
        $display("FAIL b2b_ready: cycle %0d got %b, expected 100", c, reqReady);
      end
      tick();
    end
  endtask

  task automatic test_mid_run_reset();
    logic [2:0] re;
    step(3'b111, re);
    tick();
    step(3'b111, re);
    tick();
    apply_reset_check("mid_run_reset");
    tick();
    do_init(3'b000);
    step(3'b000, re);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr_m[i] = '0;
      data_m[i] = '0;
    end
    ptr_m = 0;
    test_reset();
    test_init_sweep();
    test_request_during_init();
    test_fairness();
    test_collision();
    test_withdrawal();
    test_back_to_back();
    test_mid_run_reset();
    mon_en = 1'b0;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d writes outstanding, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the register file's single write port. After reset it sweeps all 32 registers to a known value. It then shares the write port among `NUM_REQ` independent requesters, such as ALU write-back, memory load return and I/O input, using round-robin arbitration and a valid/ready handshake. Its registered outputs drive the register file's `writeRegister`, `writeAddress` and `writeData` inputs directly.

## Interface
- `NUM_REQ`, 3: number of requesters, 2 to 4.
- `DATA_WIDTH`, 32: register data width.
- `ADDR_WIDTH`, 5: register address width; the block sweeps `2**ADDR_WIDTH` registers.
- `INIT_VALUE`, 0: value written to every register during the init sweep.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `reqValid`  in  NUM_REQ  per-requester write request.
- `reqAddress`  in  NUM_REQ*ADDR_WIDTH  packed target addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `reqData`  in  NUM_REQ*DATA_WIDTH  packed write data, same packing as `reqAddress`.
- `reqReady`  out  NUM_REQ  one-hot grant; combinational.
- `writeRegister`  out  1  register-file write enable; registered.
- `writeAddress`  out  ADDR_WIDTH  register-file write address; registered.
- `writeData`  out  DATA_WIDTH  register-file write data; registered.
- `grantIndex`  out  2  index of the requester behind the current write; registered.
- `initDone`  out  1  high once the init sweep has been issued.

## Operation
The block has two states, INIT and RUN. Reset enters INIT with the init counter at 0 and the round-robin pointer at 0.

INIT
- Each edge issues one write: `writeRegister`=1, `writeAddress`=counter, `writeData`=INIT_VALUE, `grantIndex`=0.
- The counter then increments.
- On the edge that issues address `2**ADDR_WIDTH-1`, the state moves to RUN and `initDone` is set.
- `reqReady` is all-zero throughout INIT, whatever `reqValid` does.

RUN
- Winner selection: the first requester with `reqValid` high, searching upward from the pointer and wrapping modulo NUM_REQ.
- `reqReady` is one-hot on the winner, or zero if no requester is valid.
- A transfer happens when `reqValid[i]` and `reqReady[i]` are both high at an edge.
- On a transfer edge:
  - `writeRegister`=1.
  - `writeAddress` and `writeData` take the winner's slice.
  - `grantIndex`=i.
  - The pointer becomes (i+1) mod NUM_REQ.
- On an edge with no transfer: `writeRegister`=0, and `writeAddress`, `writeData`, `grantIndex` and the pointer hold.
- Address 0 is an ordinary writable register; no address is filtered.
- Requesters must hold `reqValid`, address and data stable until accepted. Dropping `reqValid` before acceptance withdraws the request with no write.
- `reqReady` depends only on `reqValid`, state and pointer, never on `reqAddress` or `reqData`.

Boundary rules
- Several requesters targeting the same address are serialized in round-robin order. The last write wins in the register file.
- The pointer wraps from NUM_REQ-1 to 0.
- A single persistent requester is granted every cycle at full throughput.
- Asserting `resetN` low mid-sweep or mid-RUN immediately clears all outputs and returns to INIT with counter and pointer at 0. The sweep restarts from address 0 after release.

## Timing
- Reset values: `writeRegister`=0, `writeAddress`=0, `writeData`=0, `grantIndex`=0, `initDone`=0, `reqReady`=0.
- Init sweep: edge k after reset release (k = 1..32) presents address k-1.
- `initDone` rises at edge 32, together with the address-31 write, and stays high until reset.
- `reqReady` can first assert in the cycle after edge 32. The first requester write appears at edge 33 at the earliest.
- Latency from handshake edge to `writeRegister` high is 0 cycles: the outputs update on the accepting edge and are sampled by the register file on the next edge.
- Throughput is one write per cycle. No bubble is inserted between consecutive grants.

## Test plan
- Init sweep: release `resetN`, no requests, INIT_VALUE=0 → 32 consecutive cycles with `writeRegister`=1 and addresses 0..31 in order; `initDone`=1 from edge 32; `writeRegister`=0 at edge 33.
- Request during INIT: `reqValid`=3'b111 held from release → `reqReady`=0 for all of INIT. After INIT, grants go to 0, 1, 2, 0… one per cycle, each write carrying its own address and data.
- Fairness: requesters 0 and 2 continuously valid with pointer at 0 → grant sequence 0, 2, 0, 2; requester 1 never granted; `grantIndex` matches each write.
- Same-address collision: requesters 0 and 1 both write address 5, data 0xAAAA_AAAA and 0x5555_5555 → two consecutive writes to 5, 0xAAAA_AAAA then 0x5555_5555.
- Withdrawal: requester 1 asserts `reqValid` for one cycle while requester 0 wins, then drops → no write from requester 1; the pointer advances only past requester 0.
- Mid-run reset: pull `resetN` low during an active write burst → all outputs 0 immediately. After release, the sweep restarts at address 0 and `initDone` stays 0 until edge 32.
